// File: rtl/paddle_key_ctrl.sv
// paddle_key_ctrl: turns a PS/2 scan-code byte stream into paddle move
// commands, held-key flags and a launch pulse.
//
// Strobe semantics: ps2_valid qualifies ps2_byte for exactly the cycle it is
// high, and there is no back-pressure, so every valid byte is consumed that
// cycle. move_valid and launch are single-cycle strobes with no ready
// handshake. move_cmd is stable whenever move_valid is high.
//
// Scan-code parsing: E0 marks an extended code and F0 marks a break (release)
// code. Key map:
//   left  = extended 6B or plain 1C ('A')
//   right = extended 74 or plain 23 ('D')
//   space = plain 29
//
// While exactly one direction key is held, a move command is issued at once
// and then once every MOVE_PERIOD cycles.
//
// dbg_state exposes the parser state for observation. IDLE is encoded as 0.
module paddle_key_ctrl #(
  parameter int MOVE_PERIOD = 500000,
  parameter int CNT_W       = 20
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_valid,
  output logic [7:0] move_cmd,
  output logic       move_valid,
  output logic       left_held,
  output logic       right_held,
  output logic       launch,
  output logic [1:0] dbg_state
);

  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BRK   = 8'hF0;
  localparam logic [7:0] KEY_LEFT_E = 8'h6B;
  localparam logic [7:0] KEY_LEFT_P = 8'h1C;
  localparam logic [7:0] KEY_RIGHT_E = 8'h74;
  localparam logic [7:0] KEY_RIGHT_P = 8'h23;
  localparam logic [7:0] KEY_SPACE  = 8'h29;
  localparam logic [7:0] CMD_RIGHT  = 8'h00;
  localparam logic [7:0] CMD_LEFT   = 8'h01;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  state_t           state, state_nxt;
  logic             code_done, code_ext, code_brk;
  logic             hit_left, hit_right, hit_space;
  logic             space_held;
  dir_t             dir_now, dir_prev;
  logic [CNT_W-1:0] rep_cnt;

  assign dbg_state = state;

  // Parser state register; reset drops any partially received code.
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Parser next state. Also flags a completed code together with its ext/break qualifiers.
  always_comb begin
    state_nxt = state;
    code_done = 1'b0;
    code_ext  = 1'b0;
    code_brk  = 1'b0;
    if (ps2_valid) begin
      case (state)
        IDLE: begin
          if (ps2_byte == BYTE_EXT)      state_nxt = EXT;
          else if (ps2_byte == BYTE_BRK) state_nxt = BRK;
          else                           code_done = 1'b1;
        end
        EXT: begin
          if (ps2_byte == BYTE_BRK) begin
            state_nxt = EXT_BRK;
          end else begin
            state_nxt = IDLE;
            code_done = 1'b1;
            code_ext  = 1'b1;
          end
        end
        BRK: begin
          state_nxt = IDLE;
          code_done = 1'b1;
          code_brk  = 1'b1;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          code_done = 1'b1;
          code_ext  = 1'b1;
          code_brk  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Decode a completed code into the three keys we care about; anything else is ignored.
  always_comb begin
    hit_left  = 1'b0;
    hit_right = 1'b0;
    hit_space = 1'b0;
    if (code_done) begin
      hit_left  = code_ext ? (ps2_byte == KEY_LEFT_E)  : (ps2_byte == KEY_LEFT_P);
      hit_right = code_ext ? (ps2_byte == KEY_RIGHT_E) : (ps2_byte == KEY_RIGHT_P);
      hit_space = !code_ext && (ps2_byte == KEY_SPACE);
    end
  end

  // Held flags and launch. Typematic repeats re-assert the same held value, so they have no effect.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      left_held  <= 1'b0;
      right_held <= 1'b0;
      space_held <= 1'b0;
      launch     <= 1'b0;
    end else begin
      launch <= 1'b0;
      if (hit_left)  left_held  <= !code_brk;
      if (hit_right) right_held <= !code_brk;
      if (hit_space) begin
        space_held <= !code_brk;
        if (!code_brk && !space_held) launch <= 1'b1;
      end
    end
  end

  // Active direction exists only when exactly one direction key is held.
  always_comb begin
    dir_now = DIR_NONE;
    if (left_held && !right_held)      dir_now = DIR_LEFT;
    else if (right_held && !left_held) dir_now = DIR_RIGHT;
  end

  // Repeat timer: pulse on entering a direction, then once per MOVE_PERIOD cycles while it stays active.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      dir_prev   <= DIR_NONE;
      rep_cnt    <= '0;
      move_valid <= 1'b0;
      move_cmd   <= CMD_RIGHT;
    end else begin
      dir_prev   <= dir_now;
      move_valid <= 1'b0;
      if (dir_now == DIR_NONE) begin
        rep_cnt <= '0;
      end else begin
        move_cmd <= (dir_now == DIR_LEFT) ? CMD_LEFT : CMD_RIGHT;
        if (dir_now != dir_prev) begin
          rep_cnt    <= '0;
          move_valid <= 1'b1;
        end else if (rep_cnt == CNT_LAST) begin
          rep_cnt    <= '0;
          move_valid <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end

endmodule
